// File: rtl/serial_pkg.sv
// Shared definitions for the serial two's-complement datapath: FSM state
// encoding and default frame width, used by the feeder, twos_comp and deser.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Plain-vector aliases for blocks that keep state in a logic register.
    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

    function automatic logic f_any_one(input logic [DEFAULT_WIDTH-1:0] w);
        return |w;
    endfunction

endpackage

// File: rtl/serial_out_reg.sv
// One-entry valid/ready holding register. Accepts a word when empty or being
// drained this cycle; otherwise the word is dropped and overrun is latched.
module serial_out_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             nonzero_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             nonzero_q, nonzero_d;
    logic             overrun_q, overrun_d;
    logic             free_s;

    assign free_s = !valid_q || ready_i;

    // Next-state: load when free, drop-and-flag when full, clear on drain.
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        nonzero_d = nonzero_q;
        overrun_d = overrun_q;
        if (load_i) begin
            if (free_s) begin
                word_d    = data_i;
                valid_d   = 1'b1;
                nonzero_d = |data_i;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            nonzero_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            valid_q   <= valid_d;
            nonzero_q <= nonzero_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign nonzero_o = nonzero_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_word_deser.sv
// Collects an LSB-first serial bit stream into WIDTH-bit words and hands them
// to a one-entry valid/ready output register, flagging framing errors.
module serial_word_deser
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_nonzero,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] shifted_s;
    logic             done_s;

    assign shifted_s = {bit_in, shreg_q[WIDTH-1:1]};

    // FSM, bit counter and shift register next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bit_valid && frame_start) begin
                    shreg_d = shifted_s;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_valid && frame_start) begin
                    // Restart: the stale partial bits shift out over the new frame.
                    frame_err_d = 1'b1;
                    shreg_d     = shifted_s;
                    cnt_d       = CNT_W'(1);
                end else if (bit_valid) begin
                    shreg_d = shifted_s;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        done_s  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign frame_err = frame_err_q;

    serial_out_reg #(.WIDTH(WIDTH)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (done_s),
        .data_i    (shifted_s),
        .ready_i   (word_ready),
        .word_o    (word_out),
        .valid_o   (word_valid),
        .nonzero_o (word_nonzero),
        .overrun_o (overrun)
    );

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed self-checking bench for serial_word_deser (WIDTH=8).
module tb_serial_word_deser;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       bit_valid;
    logic       bit_in;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic       word_nonzero;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_total;
    int n_bad;

    serial_word_deser #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_nonzero (word_nonzero),
        .busy         (busy),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Present one bit for one cycle; called and returns on a falling edge.
    task automatic drive_bit(input logic fs, input logic b);
        frame_start = fs;
        bit_valid   = 1'b1;
        bit_in      = b;
        @(negedge clk);
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
    endtask

    // Send a full 8-bit frame, LSB first, with 'gap' idle cycles before bits 1..7.
    task automatic send_frame(input logic [7:0] w, input int gap, input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    if (i == 7 && g == gap - 1) chk({tag, "_busy_gap"}, 32'(busy), 32'd1);
                end
            end
            drive_bit((i == 0) ? 1'b1 : 1'b0, w[i]);
        end
    endtask

    logic [7:0] w;

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b1;
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        word_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_word", 32'(word_out), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Bits without frame_start in IDLE are ignored.
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        chk("idle_ign_busy", 32'(busy), 32'd0);
        chk("idle_ign_valid", 32'(word_valid), 32'd0);
        chk("idle_ign_ferr", 32'(frame_err), 32'd0);

        // 1: 0xFB with ready=1; valid exactly one clock after bit 7.
        w = 8'hFB;
        for (int i = 0; i < 7; i++) drive_bit((i == 0) ? 1'b1 : 1'b0, w[i]);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_valid_early", 32'(word_valid), 32'd0);
        drive_bit(1'b0, w[7]);
        chk("t1_valid", 32'(word_valid), 32'd1);
        chk("t1_word", 32'(word_out), 32'hFB);
        chk("t1_nz", 32'(word_nonzero), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_drain", 32'(word_valid), 32'd0);

        // 2: all-zero frame.
        send_frame(8'h00, 0, "t2");
        chk("t2_valid", 32'(word_valid), 32'd1);
        chk("t2_word", 32'(word_out), 32'h00);
        chk("t2_nz", 32'(word_nonzero), 32'd0);
        @(negedge clk);

        // 3: ready low, second frame overruns.
        word_ready = 1'b0;
        send_frame(8'h80, 0, "t3a");
        chk("t3_word1", 32'(word_out), 32'h80);
        chk("t3_ovr1", 32'(overrun), 32'd0);
        send_frame(8'h01, 0, "t3b");
        chk("t3_word2", 32'(word_out), 32'h80);
        chk("t3_valid2", 32'(word_valid), 32'd1);
        chk("t3_ovr2", 32'(overrun), 32'd1);
        word_ready = 1'b1;
        @(negedge clk);
        chk("t3_drain", 32'(word_valid), 32'd0);
        chk("t3_ovr_sticky", 32'(overrun), 32'd1);

        // 4: frame_start at bit 4 of an aborted frame, then 0xA5.
        for (int i = 0; i < 4; i++) drive_bit((i == 0) ? 1'b1 : 1'b0, 1'b1);
        chk("t4_ferr_pre", 32'(frame_err), 32'd0);
        w = 8'hA5;
        drive_bit(1'b1, w[0]);
        chk("t4_ferr", 32'(frame_err), 32'd1);
        chk("t4_no_word", 32'(word_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        drive_bit(1'b0, w[1]);
        chk("t4_ferr_pulse", 32'(frame_err), 32'd0);
        for (int i = 2; i < 8; i++) drive_bit(1'b0, w[i]);
        chk("t4_valid", 32'(word_valid), 32'd1);
        chk("t4_word", 32'(word_out), 32'hA5);
        @(negedge clk);

        // 5: one valid bit every third cycle.
        send_frame(8'h3C, 2, "t5");
        chk("t5_valid", 32'(word_valid), 32'd1);
        chk("t5_word", 32'(word_out), 32'h3C);
        @(negedge clk);

        // 6: async reset mid-frame with a held word and sticky overrun.
        word_ready = 1'b0;
        send_frame(8'h55, 0, "t6a");
        chk("t6_pre_word", 32'(word_out), 32'h55);
        for (int i = 0; i < 3; i++) drive_bit((i == 0) ? 1'b1 : 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_word", 32'(word_out), 32'h00);
        chk("t6_rst_valid", 32'(word_valid), 32'd0);
        chk("t6_rst_nz", 32'(word_nonzero), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        word_ready = 1'b1;
        @(negedge clk);
        send_frame(8'h7E, 0, "t6b");
        chk("t6_valid", 32'(word_valid), 32'd1);
        chk("t6_word", 32'(word_out), 32'h7E);
        chk("t6_nz", 32'(word_nonzero), 32'd1);
        chk("t6_ovr", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
